// File: rtl/truth_table_checker.sv
// Sweeps all sixteen {a,b,c,d} vectors into a 4-input lab circuit, samples its
// output after a settle time and scores it against a parameterised truth table.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED      = 16'h0000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_idx,
  output logic       first_fail_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_r;
  logic [3:0] idx_r;
  logic [3:0] settle_cnt_r;
  logic [3:0] vec_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [4:0] err_count_r;
  logic [3:0] first_fail_idx_r;
  logic       first_fail_valid_r;

  logic       mismatch_s;
  logic [4:0] err_next_s;

  // Compare the settled circuit output with the table entry for the held vector.
  always_comb begin
    mismatch_s = 1'b0;
    err_next_s = err_count_r;
    if (f_in != EXPECTED[idx_r]) begin
      mismatch_s = 1'b1;
      err_next_s = err_count_r + 5'd1;
    end else begin
      mismatch_s = 1'b0;
      err_next_s = err_count_r;
    end
  end

  // Sweep sequencer; every output is a register so the lab circuit sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      idx_r              <= 4'd0;
      settle_cnt_r       <= 4'd0;
      vec_r              <= 4'd0;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      pass_r             <= 1'b0;
      err_count_r        <= 5'd0;
      first_fail_idx_r   <= 4'd0;
      first_fail_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r            <= ST_WAIT;
            idx_r              <= 4'd0;
            settle_cnt_r       <= 4'd0;
            vec_r              <= 4'd0;
            busy_r             <= 1'b1;
            pass_r             <= 1'b0;
            err_count_r        <= 5'd0;
            first_fail_idx_r   <= 4'd0;
            first_fail_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          settle_cnt_r <= settle_cnt_r + 4'd1;
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_count_r <= err_next_s;
          if (mismatch_s && !first_fail_valid_r) begin
            first_fail_idx_r   <= idx_r;
            first_fail_valid_r <= 1'b1;
          end
          if (idx_r == 4'd15) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 5'd0);
          end else begin
            state_r      <= ST_WAIT;
            idx_r        <= idx_r + 4'd1;
            vec_r        <= idx_r + 4'd1;
            settle_cnt_r <= 4'd0;
          end
        end
        ST_DONE: begin
          // Vector stays at 15 during the done cycle, returns to 0 in idle.
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          vec_r   <= 4'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          vec_r   <= 4'd0;
        end
      endcase
    end
  end

  assign a                = vec_r[3];
  assign b                = vec_r[2];
  assign c                = vec_r[1];
  assign d                = vec_r[0];
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_count_r;
  assign first_fail_idx   = first_fail_idx_r;
  assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: two checker instances (settle 2 and 1) sweep a modelled lab
// circuit whose truth table is chosen per run; results are predicted by table diff.
module tb_truth_table_checker;

  localparam logic [15:0] EXP = 16'hA5C3;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ffi;
    logic       ffv;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic a0, b0, c0, d0, busy0, done0, pass0, ffv0, f0;
  logic a1, b1, c1, d1, busy1, done1, pass1, ffv1, f1;
  logic [4:0] err0, err1;
  logic [3:0] ffi0, ffi1, vec0, vec1, prev0;
  logic [15:0] model0 = EXP, model1 = EXP;
  logic glitch_en = 1'b1;

  int cyc = 0;
  int n_pass = 0, n_total = 0;
  int base0 = 0, base1 = 0;
  bit act0 = 0, act1 = 0;
  exp_t q0[$], q1[$];
  exp_t m0_e, m1_e;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    prev0 <= vec0;
  end

  assign vec0 = {a0, b0, c0, d0};
  assign vec1 = {a1, b1, c1, d1};
  // Inst0 also sees a one-cycle glitch right after each vector change.
  assign f0 = model0[vec0] ^ (glitch_en && (vec0 != prev0));
  assign f1 = model1[vec1];

  truth_table_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ffi0), .first_fail_valid(ffv0));

  truth_table_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ffi1), .first_fail_valid(ffv1));

  task automatic check(input string name, input int got, input int exp);
    n_total = n_total + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic exp_t predict(input logic [15:0] model, input int base, input int settle);
    exp_t e;
    logic [15:0] tbl;
    tbl = EXP;
    e.err = 5'd0; e.ffi = 4'd0; e.ffv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (model[i] != tbl[i]) begin
        e.err = e.err + 5'd1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = 4'(i);
        end
      end
    end
    e.pass = (e.err == 5'd0);
    e.done_cyc = base + 16 * (settle + 1);
    return e;
  endfunction

  // Result monitors: pop the prediction whenever an instance reports done.
  always @(negedge clk) begin
    if (!rst_n) q0.delete();
    else if (done0) begin
      if (q0.size() == 0) check("done0_unexpected", 1, 0);
      else begin
        m0_e = q0.pop_front();
        check("err_count0", int'(err0), int'(m0_e.err));
        check("first_fail_idx0", int'(ffi0), int'(m0_e.ffi));
        check("first_fail_valid0", int'(ffv0), int'(m0_e.ffv));
        check("pass0", int'(pass0), int'(m0_e.pass));
        check("busy0_at_done", int'(busy0), 0);
        check("done0_cycle", cyc, m0_e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q1.delete();
    else if (done1) begin
      if (q1.size() == 0) check("done1_unexpected", 1, 0);
      else begin
        m1_e = q1.pop_front();
        check("err_count1", int'(err1), int'(m1_e.err));
        check("first_fail_idx1", int'(ffi1), int'(m1_e.ffi));
        check("first_fail_valid1", int'(ffv1), int'(m1_e.ffv));
        check("pass1", int'(pass1), int'(m1_e.pass));
        check("done1_cycle", cyc, m1_e.done_cyc);
      end
    end
  end

  // Vector sequence monitors: vector k/(settle+1) during cycle k of the sweep.
  always @(negedge clk) begin
    if (act0 && rst_n && cyc >= base0 && (cyc - base0) <= 48) begin
      check("vector0", int'(vec0), ((cyc - base0) / 3 > 15) ? 15 : (cyc - base0) / 3);
      if ((cyc - base0) < 48) check("busy0_in_sweep", int'(busy0), 1);
    end
    if (act1 && rst_n && cyc >= base1 && (cyc - base1) <= 32) begin
      check("vector1", int'(vec1), ((cyc - base1) / 2 > 15) ? 15 : (cyc - base1) / 2);
    end
  end

  task automatic run0(input logic [15:0] model, input bit repulse);
    @(negedge clk);
    model0 = model;
    start0 = 1'b1;
    base0 = cyc + 1;
    act0 = 1;
    q0.push_back(predict(model, cyc + 1, 2));
    @(negedge clk);
    start0 = 1'b0;
    if (repulse) begin
      for (int i = 0; i < 100 && vec0 != 4'd4; i++) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    for (int i = 0; i < 200 && !done0; i++) @(negedge clk);
    if (!done0) check("done0_timeout", 0, 1);
    if (repulse) start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    act0 = 0;
    if (repulse) begin
      @(negedge clk);
      check("restart_in_done_ignored", int'({busy0, done0}), 0);
    end
  endtask

  task automatic run1(input logic [15:0] model);
    @(negedge clk);
    model1 = model;
    start1 = 1'b1;
    base1 = cyc + 1;
    act1 = 1;
    q1.push_back(predict(model, cyc + 1, 1));
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 100 && vec1 != 4'd4; i++) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 200 && !done1; i++) @(negedge clk);
    if (!done1) check("done1_timeout", 0, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    act1 = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs0", int'({vec0, busy0, done0, pass0, err0, ffi0, ffv0}), 0);
    check("reset_outputs1", int'({vec1, busy1, done1, pass1, err1, ffi1, ffv1}), 0);
    rst_n = 1'b1;

    run0(EXP, 0);
    run0(16'h0000, 0);
    run0(~EXP, 0);
    run0(EXP ^ 16'h0200, 0);
    repeat (4) run0(16'($urandom), 0);

    // Asynchronous reset while vector 7 is held, with errors already counted.
    @(negedge clk);
    model0 = ~EXP;
    start0 = 1'b1;
    q0.push_back(predict(~EXP, cyc + 1, 2));
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 100 && vec0 != 4'd7; i++) @(negedge clk);
    check("reached_vector7", int'(vec0), 7);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs0", int'({vec0, busy0, done0, pass0, err0, ffi0, ffv0}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run0(EXP, 0);

    run0(EXP, 1);
    run0(EXP ^ 16'h8001, 1);
    run1(EXP);
    run1(16'($urandom));
    repeat (3) @(negedge clk);
    check("scoreboard0_drained", q0.size(), 0);
    check("scoreboard1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
